// File: rtl/fp_norm_pkg.sv
// Shared constants and FSM state type for the sequential mantissa normalizer.
package fp_norm_pkg;

   localparam int MANT_W  = 24;   // mantissa width including the hidden bit
   localparam int EXP_W   = 8;    // biased exponent width
   localparam int SKIP    = 8;    // coarse shift step, one byte group
   localparam int SHIFT_W = 5;    // shift count width, holds 0..23

   localparam logic [EXP_W-1:0]   SKIP_EXP   = EXP_W'(SKIP);
   localparam logic [EXP_W-1:0]   ONE_EXP    = EXP_W'(1);
   localparam logic [SHIFT_W-1:0] SKIP_SHIFT = SHIFT_W'(SKIP);
   localparam logic [SHIFT_W-1:0] ONE_SHIFT  = SHIFT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fp_normalize_seq_if.sv
// Operand/result bus of the normalizer.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds valid and data stable until that edge; the
// consumer may raise or drop ready freely. Upstream uses i_valid/o_ready,
// downstream uses o_valid/i_ready.
interface fp_normalize_seq_if;
   import fp_norm_pkg::*;

   logic                 i_valid;
   logic                 o_ready;
   logic                 i_sign;
   logic [MANT_W-1:0]    i_mant;
   logic [EXP_W-1:0]     i_exp;
   logic                 o_valid;
   logic                 i_ready;
   logic                 o_sign;
   logic [MANT_W-1:0]    o_mant;
   logic [EXP_W-1:0]     o_exp;
   logic [SHIFT_W-1:0]   o_shift;
   logic                 o_zero;
   logic                 o_underflow;

   // Environment side: supplies operands, consumes results.
   modport master (
      output i_valid, i_sign, i_mant, i_exp, i_ready,
      input  o_ready, o_valid, o_sign, o_mant, o_exp, o_shift, o_zero, o_underflow
   );

   // Normalizer side.
   modport slave (
      input  i_valid, i_sign, i_mant, i_exp, i_ready,
      output o_ready, o_valid, o_sign, o_mant, o_exp, o_shift, o_zero, o_underflow
   );

endinterface

// File: rtl/fp_norm_step.sv
// One normalization decision on the current mantissa/exponent pair.
// Stop flags are mutually exclusive and follow the priority zero, normalized,
// underflow; when none is set the step shifts by one byte or one bit.
module fp_norm_step
   import fp_norm_pkg::*;
(
   input  logic [MANT_W-1:0]  m,
   input  logic [EXP_W-1:0]   e,
   output logic [MANT_W-1:0]  m_next,
   output logic [EXP_W-1:0]   e_next,
   output logic [SHIFT_W-1:0] inc,
   output logic               zero,
   output logic               normalized,
   output logic               underflow
);

   // Decide stop condition or shift amount; exponent never wraps below 1.
   always_comb begin
      m_next     = m;
      e_next     = e;
      inc        = '0;
      zero       = (m == '0);
      normalized = !zero && m[MANT_W-1];
      underflow  = !zero && !normalized && (e <= ONE_EXP);
      if (!zero && !normalized && !underflow) begin
         if ((m[MANT_W-1 -: SKIP] == '0) && (e > SKIP_EXP)) begin
            m_next = m << SKIP;
            e_next = e - SKIP_EXP;
            inc    = SKIP_SHIFT;
         end else begin
            m_next = m << 1;
            e_next = e - ONE_EXP;
            inc    = ONE_SHIFT;
         end
      end
   end

endmodule

// File: rtl/fp_normalize_seq.sv
// Multi-cycle left normalizer: shifts the mantissa until bit 23 is set,
// lowering the exponent by the same amount, behind a valid/ready handshake.
// A shift that lands bit 23 finishes in that same cycle, so an m=1 operand
// takes 9 SHIFT cycles (2 byte skips + 7 single shifts).
module fp_normalize_seq
   import fp_norm_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   fp_normalize_seq_if.slave bus,
   output state_t            o_state
);

   state_t               state;
   logic                 sign_q;
   logic [MANT_W-1:0]    m_q;
   logic [EXP_W-1:0]     e_q;
   logic [SHIFT_W-1:0]   cnt_q;
   logic [SHIFT_W-1:0]   cnt_next;

   logic [MANT_W-1:0]    step_m;
   logic [EXP_W-1:0]     step_e;
   logic [SHIFT_W-1:0]   step_inc;
   logic                 step_zero;
   logic                 step_norm;
   logic                 step_uflow;

   fp_norm_step u_step (
      .m          (m_q),
      .e          (e_q),
      .m_next     (step_m),
      .e_next     (step_e),
      .inc        (step_inc),
      .zero       (step_zero),
      .normalized (step_norm),
      .underflow  (step_uflow)
   );

   assign cnt_next    = cnt_q + step_inc;
   assign bus.o_ready = (state == IDLE);
   assign o_state     = state;

   // Control FSM plus working registers and registered result outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         sign_q          <= 1'b0;
         m_q             <= '0;
         e_q             <= '0;
         cnt_q           <= '0;
         bus.o_valid     <= 1'b0;
         bus.o_sign      <= 1'b0;
         bus.o_mant      <= '0;
         bus.o_exp       <= '0;
         bus.o_shift     <= '0;
         bus.o_zero      <= 1'b0;
         bus.o_underflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  sign_q <= bus.i_sign;
                  m_q    <= bus.i_mant;
                  e_q    <= bus.i_exp;
                  cnt_q  <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (step_zero) begin
                  bus.o_sign      <= sign_q;
                  bus.o_mant      <= m_q;
                  bus.o_exp       <= '0;
                  bus.o_shift     <= '0;
                  bus.o_zero      <= 1'b1;
                  bus.o_underflow <= 1'b0;
                  bus.o_valid     <= 1'b1;
                  state           <= DONE;
               end else if (step_norm) begin
                  bus.o_sign      <= sign_q;
                  bus.o_mant      <= m_q;
                  bus.o_exp       <= e_q;
                  bus.o_shift     <= cnt_q;
                  bus.o_zero      <= 1'b0;
                  bus.o_underflow <= 1'b0;
                  bus.o_valid     <= 1'b1;
                  state           <= DONE;
               end else if (step_uflow) begin
                  // Exponent exhausted: keep the partially shifted mantissa.
                  bus.o_sign      <= sign_q;
                  bus.o_mant      <= m_q;
                  bus.o_exp       <= '0;
                  bus.o_shift     <= cnt_q;
                  bus.o_zero      <= 1'b0;
                  bus.o_underflow <= 1'b1;
                  bus.o_valid     <= 1'b1;
                  state           <= DONE;
               end else begin
                  m_q   <= step_m;
                  e_q   <= step_e;
                  cnt_q <= cnt_next;
                  // Finish right away when this shift sets the top bit.
                  if (step_m[MANT_W-1]) begin
                     bus.o_sign      <= sign_q;
                     bus.o_mant      <= step_m;
                     bus.o_exp       <= step_e;
                     bus.o_shift     <= cnt_next;
                     bus.o_zero      <= 1'b0;
                     bus.o_underflow <= 1'b0;
                     bus.o_valid     <= 1'b1;
                     state           <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.i_ready) begin
                  bus.o_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               bus.o_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Directed bench for fp_normalize_seq: reset, normalized, worst case, zero,
// underflow, exponent boundaries, backpressure and mid-operation reset.
module tb_fp_normalize_seq;
   import fp_norm_pkg::*;

   logic   clk;
   logic   rst_n;
   state_t dut_state;
   int     checks;
   int     errors;

   logic [39:0] exp_q[$];

   fp_normalize_seq_if bus ();

   fp_normalize_seq dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave),
      .o_state (dut_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Driver: present an operand at a falling edge.
   task automatic drive(input logic s, input logic [23:0] m, input logic [7:0] e);
      bus.i_valid = 1'b1;
      bus.i_sign  = s;
      bus.i_mant  = m;
      bus.i_exp   = e;
   endtask

   task automatic expect_result(input logic s, input logic [23:0] m, input logic [7:0] e,
                                input logic [4:0] sh, input logic z, input logic u);
      exp_q.push_back({s, m, e, sh, z, u});
   endtask

   // Called at the falling edge right after the accept edge.
   task automatic wait_valid(input string tag, input int exp_lat);
      int lat;
      lat = 1;
      while (!bus.o_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   // Scoreboard compare of the presented result against the oldest expectation.
   task automatic check_result(input string tag);
      logic [39:0] e;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, 32'(bus.o_valid),     32'd1);
         check({tag, "_sign"},  32'(bus.o_sign),      32'(e[39]));
         check({tag, "_mant"},  32'(bus.o_mant),      32'(e[38:15]));
         check({tag, "_exp"},   32'(bus.o_exp),       32'(e[14:7]));
         check({tag, "_shift"}, 32'(bus.o_shift),     32'(e[6:2]));
         check({tag, "_zero"},  32'(bus.o_zero),      32'(e[1]));
         check({tag, "_uflow"}, 32'(bus.o_underflow), 32'(e[0]));
      end
   endtask

   task automatic release_result(input string tag);
      bus.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(bus.o_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(bus.o_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic s, input logic [23:0] m, input logic [7:0] e,
                         input logic [23:0] xm, input logic [7:0] xe, input logic [4:0] xsh,
                         input logic xz, input logic xu, input int xlat);
      @(negedge clk);
      check({tag, "_ready_idle"}, 32'(bus.o_ready), 32'd1);
      drive(s, m, e);
      expect_result(s, xm, xe, xsh, xz, xu);
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      wait_valid(tag, xlat);
      check_result(tag);
      release_result(tag);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_sign  = 1'b0;
      bus.i_mant  = '0;
      bus.i_exp   = '0;
      bus.i_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_ready", 32'(bus.o_ready), 32'd1);
      check("rst_mant",  32'(bus.o_mant),  32'd0);
      check("rst_exp",   32'(bus.o_exp),   32'd0);
      check("rst_shift", 32'(bus.o_shift), 32'd0);
      check("rst_flags", 32'({bus.o_zero, bus.o_underflow, bus.o_sign}), 32'd0);
      check("rst_state", 32'(dut_state), 32'(IDLE));
      rst_n = 1'b1;

      // tag, sign, mant, exp -> mant, exp, shift, zero, uflow, latency
      run_op("norm",      1'b0, 24'h800000, 8'd127, 24'h800000, 8'd127, 5'd0,  1'b0, 1'b0, 2);
      run_op("worst",     1'b1, 24'h000001, 8'd127, 24'h800000, 8'd104, 5'd23, 1'b0, 1'b0, 10);
      run_op("zero",      1'b0, 24'h000000, 8'd90,  24'h000000, 8'd0,   5'd0,  1'b1, 1'b0, 2);
      run_op("uflow",     1'b0, 24'h004000, 8'd5,   24'h040000, 8'd0,   5'd4,  1'b0, 1'b1, 6);
      run_op("skip_hit",  1'b1, 24'h00ABCD, 8'd20,  24'hABCD00, 8'd12,  5'd8,  1'b0, 1'b0, 2);
      run_op("skip_uf",   1'b0, 24'h000003, 8'd9,   24'h000300, 8'd0,   5'd8,  1'b0, 1'b1, 3);
      run_op("e0_uf",     1'b0, 24'h400000, 8'd0,   24'h400000, 8'd0,   5'd0,  1'b0, 1'b1, 2);
      run_op("e0_norm",   1'b1, 24'h800000, 8'd0,   24'h800000, 8'd0,   5'd0,  1'b0, 1'b0, 2);
      run_op("e8_block",  1'b0, 24'h0000FF, 8'd8,   24'h007F80, 8'd0,   5'd7,  1'b0, 1'b1, 9);
      run_op("e9_skip",   1'b0, 24'h00FFFF, 8'd9,   24'hFFFF00, 8'd1,   5'd8,  1'b0, 1'b0, 2);

      // Backpressure: result held while a new operand waits
      @(negedge clk);
      drive(1'b1, 24'h100000, 8'd50);
      expect_result(1'b1, 24'h800000, 8'd47, 5'd3, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      wait_valid("bp", 4);
      check_result("bp");
      drive(1'b0, 24'h000080, 8'd30);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_valid", 32'(bus.o_valid), 32'd1);
         check("bp_hold_ready", 32'(bus.o_ready), 32'd0);
         check("bp_hold_mant",  32'(bus.o_mant),  32'h800000);
         check("bp_hold_exp",   32'(bus.o_exp),   32'd47);
         check("bp_hold_shift", 32'(bus.o_shift), 32'd3);
         check("bp_hold_sign",  32'(bus.o_sign),  32'd1);
         check("bp_hold_state", 32'(dut_state),   32'(DONE));
      end
      bus.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_ready = 1'b0;
      check("bp_idle_ready", 32'(bus.o_ready), 32'd1);
      check("bp_idle_valid", 32'(bus.o_valid), 32'd0);
      expect_result(1'b0, 24'h800000, 8'd14, 5'd16, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      check("bp_new_taken", 32'(dut_state), 32'(SHIFT));
      wait_valid("bp_new", 3);
      check_result("bp_new");
      release_result("bp_new");

      // Reset during the third SHIFT cycle of the worst-case operand
      @(negedge clk);
      drive(1'b1, 24'h000001, 8'd127);
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("mid_in_shift", 32'(dut_state), 32'(SHIFT));
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
      check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
      check("mid_rst_mant",  32'(bus.o_mant),  32'd0);
      check("mid_rst_shift", 32'(bus.o_shift), 32'd0);
      check("mid_rst_state", 32'(dut_state),   32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 1'b0, 24'h400000, 8'd10, 24'h800000, 8'd9, 5'd1, 1'b0, 1'b0, 2);

      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
